// File: rtl/flash_loader_pkg.sv
// Shared definitions for the boot-time flash-to-RAM copy engine.
package flash_loader_pkg;

   localparam int         MEM_WORDS_DEFAULT = 10240;
   localparam logic [3:0] BE_ALL            = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_WR      = 3'd3,
      S_VF_ADDR = 3'd4,
      S_VF_CMP  = 3'd5,
      S_FIN     = 3'd6
   } state_t;

endpackage

// File: rtl/flash_to_ram_loader.sv
// Copies word_count 32-bit words from an Avalon-MM flash read port into main memory,
// optionally reading every word back and latching the index of the first mismatch.
module flash_to_ram_loader
   import flash_loader_pkg::*;
#(
   parameter int MEM_ADDR_W   = 14,
   parameter int MEM_WORDS    = MEM_WORDS_DEFAULT,
   parameter int FLASH_ADDR_W = 24,
   parameter bit VERIFY       = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [FLASH_ADDR_W-1:0] flash_base,
   input  logic [MEM_ADDR_W:0]     word_count,
   output logic [FLASH_ADDR_W-1:0] flash_address,
   output logic                    flash_read,
   input  logic                    flash_waitrequest,
   input  logic [31:0]             flash_readdata,
   input  logic                    flash_readdatavalid,
   output logic [MEM_ADDR_W-1:0]   mem_address,
   output logic [3:0]              mem_byteenable,
   output logic                    mem_chipselect,
   output logic                    mem_write,
   output logic [31:0]             mem_writedata,
   output logic                    mem_clken,
   input  logic [31:0]             mem_readdata,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [MEM_ADDR_W-1:0]   err_addr,
   output logic [2:0]              state_dbg
);

   localparam logic [MEM_ADDR_W:0]     MAX_COUNT = (MEM_ADDR_W+1)'(MEM_WORDS);
   localparam logic [MEM_ADDR_W:0]     ONE       = (MEM_ADDR_W+1)'(1);
   localparam logic [FLASH_ADDR_W-1:0] WORD_MASK = ~(FLASH_ADDR_W'(3));

   state_t                  state;
   state_t                  state_n;
   logic [MEM_ADDR_W-1:0]   idx;
   logic [MEM_ADDR_W:0]     idx_inc;
   logic [MEM_ADDR_W:0]     count_q;
   logic [FLASH_ADDR_W-1:0] base_q;
   logic [31:0]             data_q;
   logic                    error_q;
   logic [MEM_ADDR_W-1:0]   err_addr_q;

   logic accept_start;
   logic empty_run;
   logic range_err;
   logic last_word;
   logic advance;
   logic mismatch;

   assign accept_start = (state == S_IDLE) && start;
   assign empty_run    = (word_count == '0);
   assign range_err    = (word_count > MAX_COUNT);
   assign idx_inc      = {1'b0, idx} + ONE;
   assign last_word    = (idx_inc == count_q);
   assign mismatch     = (state == S_VF_CMP) && (mem_readdata != data_q);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n        = state;
      flash_read     = 1'b0;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      busy           = 1'b0;
      done           = 1'b0;
      advance        = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               // Empty and out-of-range requests finish without touching either bus.
               if (empty_run || range_err) state_n = S_FIN;
               else                        state_n = S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            busy       = 1'b1;
            flash_read = 1'b1;
            if (!flash_waitrequest) state_n = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            busy = 1'b1;
            if (flash_readdatavalid) state_n = S_WR;
         end
         S_WR: begin
            busy           = 1'b1;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            if (VERIFY) begin
               state_n = S_VF_ADDR;
            end else begin
               advance = 1'b1;
               state_n = last_word ? S_FIN : S_RD_REQ;
            end
         end
         S_VF_ADDR: begin
            busy           = 1'b1;
            mem_chipselect = 1'b1;
            state_n        = S_VF_CMP;
         end
         S_VF_CMP: begin
            busy    = 1'b1;
            advance = 1'b1;
            state_n = last_word ? S_FIN : S_RD_REQ;
         end
         S_FIN: begin
            done    = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         idx        <= '0;
         count_q    <= '0;
         base_q     <= '0;
         data_q     <= '0;
         error_q    <= 1'b0;
         err_addr_q <= '0;
      end else begin
         if (accept_start) begin
            base_q     <= flash_base & WORD_MASK;
            count_q    <= word_count;
            idx        <= '0;
            error_q    <= range_err;
            err_addr_q <= '0;
         end
         if ((state == S_RD_WAIT) && flash_readdatavalid) begin
            data_q <= flash_readdata;
         end
         // idx stays on the final word so it never leaves the memory range.
         if (advance && !last_word) begin
            idx <= idx_inc[MEM_ADDR_W-1:0];
         end
         if (mismatch && !error_q) begin
            error_q    <= 1'b1;
            err_addr_q <= idx;
         end
      end
   end

   assign flash_address  = flash_read ? (base_q + FLASH_ADDR_W'({idx, 2'b00})) : '0;
   assign mem_address    = mem_chipselect ? idx : '0;
   assign mem_writedata  = mem_write ? data_q : '0;
   assign mem_byteenable = BE_ALL;
   assign mem_clken      = reset_n;
   assign error          = error_q;
   assign err_addr       = err_addr_q;
   assign state_dbg      = state;

endmodule

// File: tb/tb_flash_to_ram_loader.sv
// Scoreboard bench for flash_to_ram_loader: randomized flash timing, reference model of
// expected flash addresses, memory writes and end-of-run results.
module tb_flash_to_ram_loader;
   import flash_loader_pkg::*;

   localparam int AW    = 14;
   localparam int FW    = 24;
   localparam int WORDS = 10240;

   logic          clk;
   logic          reset_n;
   logic          start;
   logic [FW-1:0] flash_base;
   logic [AW:0]   word_count;
   logic [FW-1:0] flash_address;
   logic          flash_read;
   logic          flash_waitrequest;
   logic [31:0]   flash_readdata;
   logic          flash_readdatavalid;
   logic [AW-1:0] mem_address;
   logic [3:0]    mem_byteenable;
   logic          mem_chipselect;
   logic          mem_write;
   logic [31:0]   mem_writedata;
   logic          mem_clken;
   logic [31:0]   mem_readdata;
   logic          busy;
   logic          done;
   logic          error;
   logic [AW-1:0] err_addr;
   logic [2:0]    state_dbg;

   flash_to_ram_loader #(
      .MEM_ADDR_W(AW), .MEM_WORDS(WORDS), .FLASH_ADDR_W(FW), .VERIFY(1'b1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .flash_base(flash_base),
      .word_count(word_count), .flash_address(flash_address), .flash_read(flash_read),
      .flash_waitrequest(flash_waitrequest), .flash_readdata(flash_readdata),
      .flash_readdatavalid(flash_readdatavalid), .mem_address(mem_address),
      .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata), .busy(busy), .done(done), .error(error),
      .err_addr(err_addr), .state_dbg(state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // scoreboard queues
   logic [FW-1:0]   fa_q[$];
   logic [AW+31:0]  wr_q[$];
   logic [AW:0]     res_q[$];

   // flash and memory model knobs
   logic [31:0] salt        = 32'h0;
   int          wait_prob   = 0;
   int          hold_left   = 0;
   int          lat_force   = 1;
   int          corrupt_idx = -1;
   int          pend        = 0;
   logic [FW-1:0] pend_addr = '0;
   bit          stall_prev  = 1'b0;
   logic [FW-1:0] prev_addr = '0;
   int          stall_cnt   = 0;
   int          n_acc       = 0;
   int          n_wr        = 0;
   int          n_done      = 0;

   function automatic logic [31:0] flash_word(input logic [FW-1:0] a);
      return {8'h00, a} ^ 32'hA5A5A5A5 ^ salt;
   endfunction

   // Reference model: what a copy of `count` words from `base` must produce.
   task automatic push_expect(input logic [FW-1:0] base, input int count, output logic [AW:0] res);
      int first_bad;
      logic [FW-1:0] a;
      first_bad = -1;
      if (count == 0) begin
         res = '0;
      end else if (count > WORDS) begin
         res = {1'b1, {AW{1'b0}}};
      end else begin
         for (int i = 0; i < count; i++) begin
            a = (base & 24'hFFFFFC) + FW'(i * 4);
            fa_q.push_back(a);
            wr_q.push_back({AW'(i), flash_word(a)});
            if (i == corrupt_idx && first_bad < 0) first_bad = i;
         end
         res = (first_bad >= 0) ? {1'b1, AW'(first_bad)} : '0;
      end
      res_q.push_back(res);
   endtask

   // flash slave model: waitrequest, response latency, address checks
   always @(negedge clk) begin
      flash_readdatavalid = 1'b0;
      flash_readdata      = $urandom;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            flash_readdatavalid = 1'b1;
            flash_readdata      = flash_word(pend_addr);
         end
      end
      if (stall_prev && reset_n) begin
         chk("flash_read_held", 64'(flash_read), 64'd1);
         chk("flash_addr_held", 64'(flash_address), 64'(prev_addr));
      end
      if (hold_left > 0 && flash_read) begin
         flash_waitrequest = 1'b1;
         hold_left--;
      end else begin
         flash_waitrequest = ($urandom_range(99) < wait_prob);
      end
      stall_prev = flash_read && flash_waitrequest && reset_n;
      prev_addr  = flash_address;
      if (stall_prev) stall_cnt++;
      if (flash_read && !flash_waitrequest && reset_n) begin
         n_acc++;
         if (fa_q.size() == 0) chk("flash_read_unexpected", 64'd1, 64'd0);
         else chk("flash_addr", 64'(flash_address), 64'(fa_q.pop_front()));
         pend      = (lat_force > 0) ? lat_force : $urandom_range(1, 3);
         pend_addr = flash_address;
      end
   end

   // main memory model, 1-cycle read, optional single-bit corruption on readback
   logic [31:0] mem [0:WORDS-1];
   initial mem_readdata = '0;
   always @(posedge clk) begin
      if (mem_chipselect && int'(mem_address) < WORDS) begin
         if (mem_write) mem[mem_address] <= mem_writedata;
         else mem_readdata <= mem[mem_address] ^ ((int'(mem_address) == corrupt_idx) ? 32'h1 : 32'h0);
      end
   end

   // monitor: memory writes and done results
   always @(negedge clk) begin
      if (reset_n && mem_write) begin
         n_wr++;
         chk("mem_write_cs_be", {59'd0, mem_chipselect, mem_byteenable}, {59'd0, 1'b1, 4'hF});
         if (wr_q.size() == 0) chk("mem_write_unexpected", 64'd1, 64'd0);
         else chk("mem_write", 64'({mem_address, mem_writedata}), 64'(wr_q.pop_front()));
      end
      if (reset_n && done) begin
         n_done++;
         chk("done_not_busy", 64'(busy), 64'd0);
         if (res_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
         else chk("result", 64'({error, err_addr}), 64'(res_q.pop_front()));
      end
   end

   // driver: one complete copy, bounded wait for done
   task automatic run_copy(input logic [FW-1:0] base, input int count, input bit spurious,
                           output int busy_cycles, output int start_to_done);
      logic [AW:0] res;
      int bound;
      bit got;
      push_expect(base, count, res);
      @(posedge clk) #1;
      flash_base = base;
      word_count = (AW+1)'(count);
      start      = 1'b1;
      @(posedge clk) #1;
      start      = 1'b0;
      flash_base = $urandom;
      word_count = (AW+1)'($urandom_range(0, 40));
      bound = (count <= WORDS) ? count * 40 + 50 : 50;
      busy_cycles = 0;
      start_to_done = 0;
      got = 1'b0;
      while (start_to_done < bound) begin
         @(negedge clk);
         start_to_done++;
         if (done) begin
            got = 1'b1;
            break;
         end
         if (busy) busy_cycles++;
         if (spurious && start_to_done == 3 && busy) start = 1'b1;
         if (start_to_done == 4) start = 1'b0;
      end
      start = 1'b0;
      if (!got) chk("done_timeout", 64'd0, 64'd1);
      @(negedge clk);
      chk("error_sticky", 64'(error), 64'(res[AW]));
      chk("flash_q_drained", 64'(fa_q.size()), 64'd0);
      chk("write_q_drained", 64'(wr_q.size()), 64'd0);
      chk("result_q_drained", 64'(res_q.size()), 64'd0);
   endtask

   initial begin
      int bc, sd, acc0, wr0, dn0, cnt, bound;
      logic [FW-1:0] b;
      logic [AW:0] res;
      reset_n = 1'b0;
      start = 1'b0;
      flash_base = '0;
      word_count = '0;
      flash_waitrequest = 1'b0;
      flash_readdata = '0;
      flash_readdatavalid = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_flash", 64'({flash_read, flash_address}), 64'd0);
      chk("rst_mem", 64'({mem_chipselect, mem_write, mem_address, mem_writedata}), 64'd0);
      chk("rst_be", 64'(mem_byteenable), 64'hF);
      chk("rst_clken", 64'(mem_clken), 64'd0);
      chk("rst_status", 64'({busy, done, error, err_addr}), 64'd0);
      chk("rst_state", 64'(state_dbg), 64'(S_IDLE));
      @(posedge clk) #1 reset_n = 1'b1;
      @(negedge clk);
      chk("clken_run", 64'(mem_clken), 64'd1);

      // basic copy, zero-wait flash
      salt = 0; wait_prob = 0; lat_force = 1; corrupt_idx = -1;
      dn0 = n_done;
      run_copy(24'h000100, 4, 1'b0, bc, sd);
      chk("t1_busy_cycles", 64'(bc), 64'd20);
      chk("t1_done_once", 64'(n_done - dn0), 64'd1);
      chk("t1_mem3", 64'(mem[3]), 64'(32'h0000010C ^ 32'hA5A5A5A5));

      // waitrequest held 7 cycles
      salt = $urandom; hold_left = 7; stall_cnt = 0;
      acc0 = n_acc; wr0 = n_wr; dn0 = n_done;
      run_copy(24'h123457, 1, 1'b0, bc, sd);
      chk("t2_stalls", 64'(stall_cnt), 64'd7);
      chk("t2_reads", 64'(n_acc - acc0), 64'd1);
      chk("t2_writes", 64'(n_wr - wr0), 64'd1);
      chk("t2_done_once", 64'(n_done - dn0), 64'd1);

      // readback corruption at word 2
      corrupt_idx = 2; wr0 = n_wr; dn0 = n_done;
      run_copy(24'h400000, 5, 1'b0, bc, sd);
      chk("t3_writes", 64'(n_wr - wr0), 64'd5);
      chk("t3_done_once", 64'(n_done - dn0), 64'd1);
      corrupt_idx = -1;

      // empty and out-of-range requests
      acc0 = n_acc; wr0 = n_wr;
      run_copy(24'h000200, 0, 1'b0, bc, sd);
      chk("t4_zero_latency_ok", 64'(sd <= 2), 64'd1);
      run_copy(24'h000300, WORDS + 1, 1'b0, bc, sd);
      chk("t4_no_reads", 64'(n_acc - acc0), 64'd0);
      chk("t4_no_writes", 64'(n_wr - wr0), 64'd0);

      // randomized runs with spurious starts while busy
      for (int r = 0; r < 6; r++) begin
         salt = $urandom;
         wait_prob = $urandom_range(0, 40);
         lat_force = 0;
         cnt = $urandom_range(1, 24);
         corrupt_idx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, cnt + 2) : -1;
         b = $urandom;
         run_copy(b, cnt, 1'b1, bc, sd);
      end
      corrupt_idx = -1;

      // full-depth copy with flash address wrap
      salt = $urandom; wait_prob = 0; lat_force = 1;
      wr0 = n_wr;
      run_copy(24'hFFFFF0, WORDS, 1'b0, bc, sd);
      chk("t5_writes", 64'(n_wr - wr0), 64'(WORDS));
      chk("t5_busy_cycles", 64'(bc), 64'(WORDS * 5));

      // reset during RD_WAIT of the fourth word, stray response afterwards
      salt = $urandom; lat_force = 4;
      wr0 = n_wr; dn0 = n_done;
      push_expect(24'h000800, 8, res);
      @(posedge clk) #1;
      flash_base = 24'h000800; word_count = 15'd8; start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      bound = 0;
      while (bound < 200 && !(n_wr - wr0 == 3 && state_dbg == 3'(S_RD_WAIT))) begin
         @(negedge clk);
         bound++;
      end
      chk("t6_reached_rd_wait", 64'(bound < 200), 64'd1);
      @(posedge clk) #1;
      reset_n = 1'b0;
      fa_q.delete(); wr_q.delete(); res_q.delete();
      @(posedge clk) #1 reset_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("t6_state_idle", 64'(state_dbg), 64'(S_IDLE));
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_no_done", 64'(n_done - dn0), 64'd0);
      chk("t6_writes", 64'(n_wr - wr0), 64'd3);
      chk("t6_error_cleared", 64'(error), 64'd0);
      lat_force = 1; salt = $urandom;
      run_copy(24'h000900, 6, 1'b0, bc, sd);
      chk("t6_clean_busy", 64'(bc), 64'd30);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
